// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one 8N1 UART transmit line between N_REQ byte producers.
// The winner's byte is latched at the grant edge and serialised LSB first at CLK_DIV clocks per bit.
module uart_tx_scheduler #(
  parameter int N_REQ   = 4,
  parameter int CLK_DIV = 434,
  parameter int DATA_W  = 8,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clc,
  input  logic                    res,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        grant,
  output logic [ID_W-1:0]         cur_id,
  output logic                    busy,
  output logic                    TX
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [BAUD_W-1:0]   baud_cnt, baud_nxt;
  logic [BIT_W-1:0]    bit_cnt, bit_nxt;
  logic [DATA_W-1:0]   shreg, shreg_nxt;
  logic [ID_W-1:0]     rr_ptr, rr_nxt;
  logic [ID_W-1:0]     cur_id_nxt;
  logic [N_REQ-1:0]    grant_nxt;
  logic                busy_nxt;
  logic                tx_nxt;
  logic                bit_end;

  logic                found;
  logic [ID_W-1:0]     win;
  logic [ID_W:0]       idx;
  logic [DATA_W-1:0]   win_byte;

  // First pending request at or after the rotating pointer, wrapping past N_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (idx >= (ID_W+1)'(N_REQ)) idx = idx - (ID_W+1)'(N_REQ);
      if (!found && req[idx[ID_W-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == ID_W'(k)) win_byte = data[k*DATA_W +: DATA_W];
    end
  end

  assign bit_end = (baud_cnt == BAUD_W'(CLK_DIV - 1));

  always_comb begin
    state_nxt  = state;
    baud_nxt   = baud_cnt + BAUD_W'(1);
    bit_nxt    = bit_cnt;
    shreg_nxt  = shreg;
    rr_nxt     = rr_ptr;
    cur_id_nxt = cur_id;
    grant_nxt  = '0;
    busy_nxt   = busy;
    tx_nxt     = TX;
    case (state)
      IDLE: begin
        baud_nxt = '0;
        if (found) begin
          state_nxt  = START;
          shreg_nxt  = win_byte;
          cur_id_nxt = win;
          rr_nxt     = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
          grant_nxt  = N_REQ'(1) << win;
          busy_nxt   = 1'b1;
          tx_nxt     = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          baud_nxt  = '0;
          bit_nxt   = '0;
          tx_nxt    = shreg[0];
          shreg_nxt = {1'b0, shreg[DATA_W-1:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_nxt = '0;
          if (bit_cnt == BIT_W'(DATA_W - 1)) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_nxt   = bit_cnt + BIT_W'(1);
            tx_nxt    = shreg[0];
            shreg_nxt = {1'b0, shreg[DATA_W-1:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          baud_nxt  = '0;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        baud_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clc or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      rr_ptr   <= '0;
      cur_id   <= '0;
      grant    <= '0;
      busy     <= 1'b0;
      TX       <= 1'b1;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      rr_ptr   <= rr_nxt;
      cur_id   <= cur_id_nxt;
      grant    <= grant_nxt;
      busy     <= busy_nxt;
      TX       <= tx_nxt;
    end
  end

  // Payload shifter is pure datapath; its content is only observed after a load.
  always_ff @(posedge clc) begin
    shreg <= shreg_nxt;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomised bench for uart_tx_scheduler against a queue-based waveform model of the UART scheduler.
module tb_uart_tx_scheduler;

  localparam int N_REQ   = 4;
  localparam int CLK_DIV = 4;
  localparam int DATA_W  = 8;
  localparam int ID_W    = 2;

  logic                    clc = 1'b0;
  logic                    res = 1'b1;
  logic [N_REQ-1:0]        req = '0;
  logic [N_REQ*DATA_W-1:0] data = '0;
  logic [N_REQ-1:0]        grant;
  logic [ID_W-1:0]         cur_id;
  logic                    busy;
  logic                    TX;

  uart_tx_scheduler #(.N_REQ(N_REQ), .CLK_DIV(CLK_DIV), .DATA_W(DATA_W)) dut (
    .clc(clc), .res(res), .req(req), .data(data),
    .grant(grant), .cur_id(cur_id), .busy(busy), .TX(TX)
  );

  always #5 clc = ~clc;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // Reference model: expected line levels for the frame in flight, plus arbitration state.
  bit               m_q[$];
  int               m_rr   = 0;
  int               m_cur  = 0;
  bit               m_busy = 1'b0;
  bit               m_tx   = 1'b1;
  logic [N_REQ-1:0] m_grant = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp_v, cyc);
  endtask

  task automatic model_edge();
    int w;
    logic [DATA_W-1:0] b;
    w = -1;
    m_grant = '0;
    if (m_q.size() == 0 && !m_busy && (|req)) begin
      for (int k = 0; k < N_REQ; k++) begin
        int i;
        i = (m_rr + k) % N_REQ;
        if (w < 0 && req[i]) w = i;
      end
      b = data[w*DATA_W +: DATA_W];
      for (int s = 0; s < 10; s++) begin
        bit lvl;
        if (s == 0) lvl = 1'b0;
        else if (s == 9) lvl = 1'b1;
        else lvl = b[s-1];
        for (int c = 0; c < CLK_DIV; c++) m_q.push_back(lvl);
      end
      m_grant = N_REQ'(1) << w;
      m_cur   = w;
      m_rr    = (w + 1) % N_REQ;
    end
    if (m_q.size() > 0) begin
      m_tx   = m_q.pop_front();
      m_busy = 1'b1;
    end else begin
      m_tx   = 1'b1;
      m_busy = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clc);
    @(negedge clc);
    cyc++;
    chk("tx",     32'(TX),     32'(m_tx));
    chk("busy",   32'(busy),   32'(m_busy));
    chk("grant",  32'(grant),  32'(m_grant));
    chk("cur_id", 32'(cur_id), 32'(m_cur));
  endtask

  task automatic do_reset();
    req = '0;
    res = 1'b0;
    #1;
    chk("rst_tx",     32'(TX),     32'd1);
    chk("rst_busy",   32'(busy),   32'd0);
    chk("rst_grant",  32'(grant),  32'd0);
    chk("rst_cur_id", 32'(cur_id), 32'd0);
    m_q.delete();
    m_rr = 0; m_cur = 0; m_busy = 1'b0; m_tx = 1'b1; m_grant = '0;
    @(negedge clc);
    @(negedge clc);
    res = 1'b1;
  endtask

  task automatic run_until_grant(input string tag, input int max_cyc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      tick();
      if (m_grant != '0) got = 1'b1;
    end
    if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    logic [9:0] cap;
    int         busy_cnt;
    int         g_cnt;
    logic [N_REQ-1:0] gq[$];
    int         tq[$];

    #2;
    do_reset();

    // Idle with no requests
    for (int i = 0; i < 100; i++) tick();

    // Single request from requester 2 carrying A5
    data[23:16] = 8'hA5;
    req = 4'b0100;
    run_until_grant("t2", 10);
    chk("t2_grant", 32'(grant), 32'h4);
    chk("t2_cur", 32'(cur_id), 32'd2);
    req = '0;
    cap = '0;
    busy_cnt = (busy) ? 1 : 0;
    cap[0] = TX;
    for (int t = 1; t < 50; t++) begin
      tick();
      if (busy) busy_cnt++;
      if ((t % CLK_DIV) == 1 && (t / CLK_DIV) < 10) cap[t / CLK_DIV] = TX;
    end
    chk("t2_frame", 32'(cap), 32'h34A);
    chk("t2_busy_len", 32'(busy_cnt), 32'd40);

    // All four requesting, dropped after each grant
    do_reset();
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    req = 4'b1111;
    for (int i = 0; i < 170; i++) begin
      tick();
      if (grant != '0) begin
        gq.push_back(grant);
        tq.push_back(cyc);
      end
      req = req & ~m_grant;
    end
    chk("t3_ngrants", 32'(gq.size()), 32'd4);
    for (int i = 0; i < gq.size(); i++) begin
      chk("t3_order", 32'(gq[i]), 32'(1 << i));
      if (i > 0) chk("t3_spacing", 32'(tq[i] - tq[i-1]), 32'd41);
    end

    // Pointer wrap: 3 was served last, so 0 wins over 3
    data[7:0] = 8'h55;
    data[31:24] = 8'hC3;
    req = 4'b1001;
    run_until_grant("t4a", 10);
    chk("t4_first", 32'(grant), 32'h1);
    chk("t4_first_id", 32'(cur_id), 32'd0);
    req[0] = 1'b0;
    run_until_grant("t4b", 60);
    chk("t4_second", 32'(grant), 32'h8);
    chk("t4_second_id", 32'(cur_id), 32'd3);
    req = '0;
    for (int i = 0; i < 45; i++) tick();

    // Reset during data bit 3 of FF, then a fresh frame
    data[7:0] = 8'hFF;
    req = 4'b0001;
    run_until_grant("t5a", 10);
    req = '0;
    for (int i = 0; i < 17; i++) tick();
    chk("t5_pre_busy", 32'(busy), 32'd1);
    do_reset();
    data[7:0] = 8'h3C;
    req = 4'b0001;
    run_until_grant("t5b", 10);
    chk("t5_regrant", 32'(grant), 32'h1);
    req = '0;
    for (int i = 0; i < 45; i++) tick();

    // Request held through several frames
    data[7:0] = 8'h81;
    req = 4'b0001;
    g_cnt = 0;
    for (int i = 0; i < 123; i++) begin
      tick();
      if (grant != '0) g_cnt++;
    end
    chk("t6_grants", 32'(g_cnt), 32'd3);
    req = '0;
    for (int i = 0; i < 45; i++) tick();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      tick();
      for (int r = 0; r < N_REQ; r++) begin
        if (req[r] && m_grant[r]) begin
          if ($urandom_range(3) != 0) req[r] = 1'b0;
        end else if (!req[r] && $urandom_range(19) == 0) begin
          data[r*DATA_W +: DATA_W] = 8'($urandom);
          req[r] = 1'b1;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Round-robin scheduler that shares one UART transmit line between N_REQ byte producers.
- Arbitrates pending requests, latches the winner's byte and serialises it as an 8N1 frame on TX at a fixed baud set by a clock divider.
- Sits between the on-chip producers (loopback echo, status reporters) and the board TX pin; it is the only block that drives TX.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLK_DIV, 434, clocks per bit (50 MHz / 115200); minimum 2
DATA_W, 8, bits per frame payload (fixed 8N1 framing)

Ports:
clc  input  1  system clock, rising edge
res  input  1  asynchronous active-low reset
req  input  N_REQ  request per requester; held high until granted
data  input  N_REQ*DATA_W  flattened bytes; requester i at [DATA_W*i+DATA_W-1 : DATA_W*i]
grant  output  N_REQ  one-hot, one-clock accept pulse
cur_id  output  $clog2(N_REQ)  index of requester owning the current or last frame
busy  output  1  high while a frame is in progress
TX  output  1  serial line, idle high

Behaviour:
- Reset (async, res low): TX=1, grant=0, busy=0, cur_id=0, rr pointer=0, state=IDLE, bit/baud counters=0. Asserting reset mid-frame forces TX=1 immediately; a partial frame is abandoned, with no resume after release.
- States: IDLE -> START -> DATA -> STOP -> IDLE. All outputs are registered.
- Baud counter counts 0..CLK_DIV-1. Each state bit lasts exactly CLK_DIV clocks. Counter clears on every state entry.
- IDLE, edge E with |req=1:
  - Winner is the first set req at or after the rr pointer, scanning upward with wrap from N_REQ-1 to 0.
  - At E: shift reg <= winner's byte; cur_id <= winner; rr pointer <= winner+1 mod N_REQ; TX <= 0; busy <= 1; state <= START; grant <= onehot(winner).
  - grant is high for exactly the one clock after E, then returns to 0.
- Requester contract:
  - data is sampled at E.
  - The requester sees grant at E+1 and must drop or replace req/data after that.
  - A req still high during START/DATA/STOP is ignored and does not queue.
- START: TX=0 for CLK_DIV clocks, then DATA.
- DATA: 8 bits, LSB first. TX=bit k for CLK_DIV clocks each. Bit counter 0..7; after bit 7 -> STOP.
- STOP: TX=1 for CLK_DIV clocks. At the final edge, state <= IDLE and busy <= 0.
- Frame length: TX low from edge E, back high at E+CLK_DIV*9, busy falls at E+CLK_DIV*10.
- Back-to-back frames: the earliest next arbitration is the first IDLE edge, one clock after busy falls. Minimum idle gap on TX between frames is CLK_DIV+1 clocks of high, counting the stop bit.
- Fairness: with all req held high, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 frames.
- Simultaneous requests: resolved only by the rr pointer, never by fixed priority.
- req toggling while the block is in IDLE with no grant has no side effect. req=0 everywhere keeps the block in IDLE with TX=1 indefinitely.

Test Plan:
1. Reset then idle, N_REQ=4, CLK_DIV=4, req=0 for 100 clocks -> TX=1, busy=0, grant=0, cur_id=0 throughout.
2. Single request, req=4'b0100, data[23:16]=8'hA5 -> grant=4'b0100 for 1 clock, cur_id=2. TX sequence is 0,1,0,1,0,0,1,0,1,1 (start, A5 LSB-first, stop), each level held 4 clocks. busy high for 40 clocks.
3. All four requesting with bytes 8'h10,8'h11,8'h12,8'h13, req held and dropped one clock after each grant -> frames emitted in order 10,11,12,13. grant pulses are 0001,0010,0100,1000. Spacing is 41 clocks between grant pulses.
4. Pointer wrap: after requester 3 is served, assert req=4'b1001 -> requester 0 granted first, then 3.
5. Reset mid-frame: assert res low during DATA bit 3 of 8'hFF -> TX=1 in the same cycle, busy=0, grant=0. After release with req=0001, a complete new frame starts from the start bit and rr pointer=0.
6. req held during a frame: req=0001 held continuously -> exactly one grant per frame, with frames back-to-back at 41-clock period and no extra grant pulses mid-frame.
